sram_arbiter: RTL and testbench
===============================

Name: sram_arbiter

Overview:
- Shares the single BaseRAM SRAM chip between the instruction-fetch master (ibus) and the data master (dbus).
- Sequences the SRAM timing for each access:
  - read bursts of 1-4 words, returned as a 128-bit line;
  - single-word byte-enabled writes with setup, pulse and hold phases.
- Owns the bidirectional base_ram_data bus.
- Sits between the CPU bus masters and the top-level SRAM pins.

Parameters:
- READ_WAIT, 1, extra cycles each read word is held before sampling. Word period = READ_WAIT+1.
- WRITE_WAIT, 1, cycles base_ram_we_n is held low per write. Minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- ibus_req  in  1  fetch read request; held until ibus_ok.
- ibus_addr  in  32  byte address; bits [1:0] ignored.
- ibus_burst  in  2  words minus one (0..3).
- ibus_rdata  out  128  word i in bits [32*i+31:32*i].
- ibus_ok  out  1  one-cycle completion pulse.
- dbus_req  in  1  data request; held until dbus_ok.
- dbus_we  in  1  1 = write, 0 = read.
- dbus_addr  in  32  byte address.
- dbus_be_n  in  4  write byte enables, low active.
- dbus_wdata  in  32  write data.
- dbus_burst  in  2  read words minus one; ignored on writes.
- dbus_rdata  out  128  as ibus_rdata.
- dbus_ok  out  1  one-cycle completion pulse.
- base_ram_data  inout  32  SRAM data bus.
- base_ram_addr  out  20  SRAM word address.
- base_ram_be_n  out  4  SRAM byte enables.
- base_ram_ce_n, base_ram_oe_n, base_ram_we_n  out  1 each  SRAM controls, low active.

Behaviour:
- Reset values (asynchronous on rst=0):
  - ce_n = oe_n = we_n = 1, be_n = 4'hF, base_ram_addr = 0;
  - data bus high-Z;
  - both ok = 0, both rdata = 0, state IDLE.
- Reset during an access: the access is abandoned and no ok is issued.
- States:
  - IDLE: sample req and grant a master.
    - Read grant -> READ with word counter = 0.
    - dbus write grant -> WR_SETUP.
  - READ:
    - ce_n = 0, oe_n = 0, be_n = 0;
    - addr = base + counter, where base = addr[21:2]; the 20-bit sum wraps (20'hFFFFF + 1 = 0);
    - base_ram_data is sampled into the granted rdata slot on the last cycle of each word period;
    - after word `burst` -> DONE.
  - WR_SETUP (1 cycle): ce_n = 0, we_n = 1; addr, be_n = dbus_be_n and data driven.
  - WR_PULSE (WRITE_WAIT cycles): we_n = 0; addr, be_n and data stable.
  - WR_HOLD (1 cycle): we_n = 1, data still driven. Then -> DONE.
  - DONE (1 cycle): granted ok = 1, ce_n = 1. Then -> IDLE.
- Data bus drive: driven only in the WR_* states, high-Z otherwise. No cycle has both oe_n = 0 and the bus driven.
- Latency, request first seen in IDLE at cycle T:
  - ok is high in cycle T + 1 + (burst+1)*(READ_WAIT+1) for a read;
  - ok is high in cycle T + 3 + WRITE_WAIT for a write.
- Handshake:
  - the master holds req, addr and the other request fields constant until ok;
  - req must be low in the cycle after ok, otherwise a new transaction starts;
  - rdata is valid from the ok cycle and held until that master's next read.
- Untouched slots: on a burst shorter than 4, the unused rdata slots keep their previous contents.
- Arbitration with both requests in IDLE: dbus wins by default (fixed priority). The losing request stays pending and is granted in the next IDLE.
- Requests arriving mid-transaction are not acknowledged until their own grant.

Optional Feature:
- Macro: SRAM_ARB_RR_EN.
- Defined: round-robin arbitration.
  - A last-grant flag updates on each grant.
  - On a tie, the master not granted last wins.
  - The flag resets to ibus, so dbus wins the first tie.
- Undefined: fixed dbus priority. No last-grant register is built.

Decomposition:
- Package sram_pkg:
  - state enum (IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE);
  - master_t enum (M_IBUS, M_DBUS);
  - burst_t (logic[1:0]);
  - SRAM_ADDR_W = 20.
- Sub-module sram_arb_grant: combinational pick of the master from the two reqs plus the last-grant flag. The registered flag lives in sram_arb_grant and is present only under SRAM_ARB_RR_EN.

Test Plan:
- ibus read, addr 32'h0000_0010, burst 3, SRAM model words 0x11,0x22,0x33,0x44 at word addresses 4..7 -> base_ram_addr steps 4,5,6,7 every 2 cycles with oe_n = 0; ibus_ok in cycle T+9; ibus_rdata = 128'h00000044_00000033_00000022_00000011.
- dbus write, addr 32'h0000_0100, be_n 4'b1100, wdata 32'hABCD1234 -> we_n low for exactly 1 cycle at addr 20'h40 with be_n 4'b1100; bus driven only in WR_* states; dbus_ok in cycle T+4; model byte lanes 0-1 = 0x1234, lanes 2-3 unchanged.
- ibus_req and dbus_req (read) both raised in the same cycle -> dbus served first, ibus granted in the following IDLE. With SRAM_ARB_RR_EN, a second simultaneous pair is served ibus first.
- Read at addr 32'h003F_FFFC, burst 1 -> base_ram_addr 20'hFFFFF, then 20'h00000.
- rst pulled low during WR_PULSE -> we_n = 1, ce_n = 1 and the bus high-Z immediately (asynchronously); no dbus_ok ever; first access after release is correct.
- Random mixed ibus/dbus traffic against a behavioural SRAM model -> every completed read matches the model; oe_n = 0 and bus-driven never overlap; every ok is a single-cycle pulse.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared types for the BaseRAM arbiter: FSM states, master identifiers and
// the SRAM word-address width.
package sram_pkg;

    localparam int SRAM_ADDR_W = 20;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD,
        DONE
    } state_t;

    typedef enum logic {
        M_IBUS,
        M_DBUS
    } master_t;

    typedef logic [1:0] burst_t;

endpackage

// File: rtl/sram_arb_grant.sv
// Picks which master is granted from the two requests. With SRAM_ARB_RR_EN
// defined a last-grant flag gives round-robin on ties; otherwise dbus always wins.
module sram_arb_grant
    import sram_pkg::*;
(
    input  logic    clk,
    input  logic    rst,
    input  logic    ibus_req,
    input  logic    dbus_req,
    input  logic    grant_en,
    output master_t pick
);

`ifdef SRAM_ARB_RR_EN
    master_t last_grant;

    // Starts at ibus so the very first tie goes to dbus.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= M_IBUS;
        end else if (grant_en) begin
            last_grant <= pick;
        end
    end

    always_comb begin
        pick = M_DBUS;
        if (ibus_req && dbus_req) begin
            pick = (last_grant == M_DBUS) ? M_IBUS : M_DBUS;
        end else if (ibus_req) begin
            pick = M_IBUS;
        end
    end
`else
    logic unused_rr_inputs;
    assign unused_rr_inputs = &{1'b0, clk, rst, grant_en, ibus_req};

    always_comb begin
        pick = dbus_req ? M_DBUS : M_IBUS;
    end
`endif

endmodule

// File: rtl/sram_arbiter.sv
// Shares the BaseRAM SRAM between the ibus and dbus masters and sequences its
// read-burst and write timing. Define SRAM_ARB_RR_EN for round-robin arbitration.
module sram_arbiter
    import sram_pkg::*;
#(
    parameter int READ_WAIT  = 1,
    parameter int WRITE_WAIT = 1
) (
    input  logic                   clk,
    input  logic                   rst,

    input  logic                   ibus_req,
    input  logic [31:0]            ibus_addr,
    input  logic [1:0]             ibus_burst,
    output logic [127:0]           ibus_rdata,
    output logic                   ibus_ok,

    input  logic                   dbus_req,
    input  logic                   dbus_we,
    input  logic [31:0]            dbus_addr,
    input  logic [3:0]             dbus_be_n,
    input  logic [31:0]            dbus_wdata,
    input  logic [1:0]             dbus_burst,
    output logic [127:0]           dbus_rdata,
    output logic                   dbus_ok,

    inout  wire  [31:0]            base_ram_data,
    output logic [SRAM_ADDR_W-1:0] base_ram_addr,
    output logic [3:0]             base_ram_be_n,
    output logic                   base_ram_ce_n,
    output logic                   base_ram_oe_n,
    output logic                   base_ram_we_n
);

    state_t                 state;
    state_t                 state_nx;
    master_t                pick;
    master_t                master_q;
    burst_t                 burst_q;
    burst_t                 word_cnt;
    logic [7:0]             wait_cnt;
    logic [SRAM_ADDR_W-1:0] base_q;
    logic [3:0]             be_q;
    logic [31:0]            wdata_q;
    logic                   grant_en;
    logic                   word_last;
    logic                   pulse_last;
    logic                   drive_bus;

    logic unused_addr_bits;
    assign unused_addr_bits = &{1'b0, ibus_addr[31:22], ibus_addr[1:0],
                                dbus_addr[31:22], dbus_addr[1:0]};

    assign grant_en   = (state == IDLE) && (ibus_req || dbus_req);
    assign word_last  = (wait_cnt == 8'(READ_WAIT));
    assign pulse_last = (wait_cnt == 8'(WRITE_WAIT - 1));

    sram_arb_grant u_grant (
        .clk      (clk),
        .rst      (rst),
        .ibus_req (ibus_req),
        .dbus_req (dbus_req),
        .grant_en (grant_en),
        .pick     (pick)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (grant_en) begin
                    state_nx = (pick == M_DBUS && dbus_we) ? WR_SETUP : READ;
                end
            end
            READ: begin
                if (word_last && word_cnt == burst_q) begin
                    state_nx = DONE;
                end
            end
            WR_SETUP: state_nx = WR_PULSE;
            WR_PULSE: begin
                if (pulse_last) begin
                    state_nx = WR_HOLD;
                end
            end
            WR_HOLD:  state_nx = DONE;
            DONE:     state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    // Pin controls are decoded purely from state, so an async reset parks them immediately.
    always_comb begin
        base_ram_ce_n = 1'b1;
        base_ram_oe_n = 1'b1;
        base_ram_we_n = 1'b1;
        base_ram_be_n = 4'hF;
        base_ram_addr = '0;
        drive_bus     = 1'b0;
        case (state)
            READ: begin
                base_ram_ce_n = 1'b0;
                base_ram_oe_n = 1'b0;
                base_ram_be_n = 4'h0;
                base_ram_addr = base_q + SRAM_ADDR_W'(word_cnt);
            end
            WR_SETUP, WR_HOLD: begin
                base_ram_ce_n = 1'b0;
                base_ram_be_n = be_q;
                base_ram_addr = base_q;
                drive_bus     = 1'b1;
            end
            WR_PULSE: begin
                base_ram_ce_n = 1'b0;
                base_ram_we_n = 1'b0;
                base_ram_be_n = be_q;
                base_ram_addr = base_q;
                drive_bus     = 1'b1;
            end
            default: ;
        endcase
    end

    assign base_ram_data = drive_bus ? wdata_q : 32'bz;

    assign ibus_ok = (state == DONE) && (master_q == M_IBUS);
    assign dbus_ok = (state == DONE) && (master_q == M_DBUS);

    // Request fields are captured at grant; only the addressed rdata slot is overwritten per word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            master_q   <= M_IBUS;
            burst_q    <= '0;
            word_cnt   <= '0;
            wait_cnt   <= '0;
            base_q     <= '0;
            be_q       <= 4'hF;
            wdata_q    <= '0;
            ibus_rdata <= '0;
            dbus_rdata <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (grant_en) begin
                        master_q <= pick;
                        word_cnt <= '0;
                        wait_cnt <= '0;
                        if (pick == M_DBUS) begin
                            base_q  <= dbus_addr[21:2];
                            burst_q <= dbus_burst;
                            be_q    <= dbus_be_n;
                            wdata_q <= dbus_wdata;
                        end else begin
                            base_q  <= ibus_addr[21:2];
                            burst_q <= ibus_burst;
                        end
                    end
                end
                READ: begin
                    if (word_last) begin
                        if (master_q == M_DBUS) begin
                            dbus_rdata[{word_cnt, 5'b0} +: 32] <= base_ram_data;
                        end else begin
                            ibus_rdata[{word_cnt, 5'b0} +: 32] <= base_ram_data;
                        end
                        word_cnt <= word_cnt + 2'd1;
                        wait_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WR_PULSE: wait_cnt <= wait_cnt + 8'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed and light random bench for sram_arbiter with a behavioural BaseRAM
// model (1K words, aliased on the low 10 address bits).
module tb_sram_arbiter;

    logic         clk;
    logic         rst;
    logic         ibus_req;
    logic [31:0]  ibus_addr;
    logic [1:0]   ibus_burst;
    logic [127:0] ibus_rdata;
    logic         ibus_ok;
    logic         dbus_req;
    logic         dbus_we;
    logic [31:0]  dbus_addr;
    logic [3:0]   dbus_be_n;
    logic [31:0]  dbus_wdata;
    logic [1:0]   dbus_burst;
    logic [127:0] dbus_rdata;
    logic         dbus_ok;
    wire  [31:0]  base_ram_data;
    logic [19:0]  base_ram_addr;
    logic [3:0]   base_ram_be_n;
    logic         base_ram_ce_n;
    logic         base_ram_oe_n;
    logic         base_ram_we_n;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    sram_arbiter dut (
        .clk           (clk),
        .rst           (rst),
        .ibus_req      (ibus_req),
        .ibus_addr     (ibus_addr),
        .ibus_burst    (ibus_burst),
        .ibus_rdata    (ibus_rdata),
        .ibus_ok       (ibus_ok),
        .dbus_req      (dbus_req),
        .dbus_we       (dbus_we),
        .dbus_addr     (dbus_addr),
        .dbus_be_n     (dbus_be_n),
        .dbus_wdata    (dbus_wdata),
        .dbus_burst    (dbus_burst),
        .dbus_rdata    (dbus_rdata),
        .dbus_ok       (dbus_ok),
        .base_ram_data (base_ram_data),
        .base_ram_addr (base_ram_addr),
        .base_ram_be_n (base_ram_be_n),
        .base_ram_ce_n (base_ram_ce_n),
        .base_ram_oe_n (base_ram_oe_n),
        .base_ram_we_n (base_ram_we_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            0:       return 32'hCAFE_0000;
            4:       return 32'h0000_0011;
            5:       return 32'h0000_0022;
            6:       return 32'h0000_0033;
            7:       return 32'h0000_0044;
            64:      return 32'h5566_7788;
            1023:    return 32'hCAFE_0001;
            default: return 32'h5A00_0000 + 32'(i);
        endcase
    endfunction

    // SRAM model: combinational read when selected, byte-lane write while we_n is low.
    logic [31:0] mem [0:1023];
    assign base_ram_data = (!base_ram_ce_n && !base_ram_oe_n) ? mem[base_ram_addr[9:0]] : 32'bz;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = init_word(i);
        forever begin
            @(negedge clk);
            if (!base_ram_ce_n && !base_ram_we_n) begin
                for (int b = 0; b < 4; b++) begin
                    if (!base_ram_be_n[b]) mem[base_ram_addr[9:0]][8*b +: 8] = base_ram_data[8*b +: 8];
                end
            end
        end
    end

    logic [19:0] addr_log [$];
    int          we_cnt = 0;
    logic [19:0] we_addr;
    logic [3:0]  we_be;
    logic [31:0] we_data;
    logic        prev_ibus_ok = 1'b0;
    logic        prev_dbus_ok = 1'b0;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    always @(negedge clk) begin
        if (!base_ram_oe_n) addr_log.push_back(base_ram_addr);
        if (!base_ram_we_n) begin
            we_cnt++;
            we_addr = base_ram_addr;
            we_be   = base_ram_be_n;
            we_data = base_ram_data;
        end
        checkOutput("oe_drive_overlap", 128'(dut.drive_bus & ~base_ram_oe_n), 128'd0);
        checkOutput("drive_outside_wr", 128'(dut.drive_bus & base_ram_ce_n), 128'd0);
        checkOutput("ibus_ok_pulse", 128'(ibus_ok & prev_ibus_ok), 128'd0);
        checkOutput("dbus_ok_pulse", 128'(dbus_ok & prev_dbus_ok), 128'd0);
        prev_ibus_ok = ibus_ok;
        prev_dbus_ok = dbus_ok;
    end

    task automatic applyStimulus(input bit is_d, input bit we, input logic [31:0] addr,
                                 input logic [1:0] burst, input logic [3:0] be_n,
                                 input logic [31:0] wdata, output int lat, output logic [127:0] line);
        int t0;
        @(posedge clk);
        #1;
        if (is_d) begin
            dbus_we = we; dbus_addr = addr; dbus_burst = burst;
            dbus_be_n = be_n; dbus_wdata = wdata; dbus_req = 1'b1;
        end else begin
            ibus_addr = addr; ibus_burst = burst; ibus_req = 1'b1;
        end
        t0   = cyc;
        lat  = -1;
        line = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (is_d ? dbus_ok : ibus_ok) begin
                lat  = cyc - t0;
                line = is_d ? dbus_rdata : ibus_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        ibus_req = 1'b0;
        dbus_req = 1'b0;
        dbus_we  = 1'b0;
    endtask

    task automatic applyTieStimulus(input logic [31:0] d_addr, input logic [1:0] d_burst,
                                    input logic [31:0] i_addr, input logic [1:0] i_burst,
                                    output bit first_is_d, output int lat1, output int lat2,
                                    output logic [127:0] d_line, output logic [127:0] i_line);
        int t0;
        @(posedge clk);
        #1;
        dbus_we = 1'b0; dbus_addr = d_addr; dbus_burst = d_burst; dbus_req = 1'b1;
        ibus_addr = i_addr; ibus_burst = i_burst; ibus_req = 1'b1;
        t0 = cyc;
        first_is_d = 1'b0;
        lat1 = -1; lat2 = -1; d_line = '0; i_line = '0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (ibus_ok || dbus_ok) begin
                first_is_d = dbus_ok;
                lat1 = cyc - t0;
                if (dbus_ok) d_line = dbus_rdata;
                else         i_line = ibus_rdata;
                break;
            end
        end
        @(posedge clk);
        #1;
        if (lat1 >= 0) begin
            if (first_is_d) dbus_req = 1'b0;
            else            ibus_req = 1'b0;
            for (int k = 0; k < 60; k++) begin
                @(negedge clk);
                if (first_is_d ? ibus_ok : dbus_ok) begin
                    lat2 = cyc - t0;
                    if (first_is_d) i_line = ibus_rdata;
                    else            d_line = dbus_rdata;
                    break;
                end
            end
            @(posedge clk);
            #1;
        end
        ibus_req = 1'b0;
        dbus_req = 1'b0;
    endtask

    logic [31:0]  shadow [0:1023];
    logic [127:0] exp_line;
    logic [127:0] exp_ibus;
    logic [127:0] exp_dbus;
    logic [127:0] line;
    logic [127:0] d_line;
    logic [127:0] i_line;
    logic [19:0]  wrap_exp [4];
    int           lat;
    int           lat1;
    int           lat2;
    int           n0;
    int           w0;
    bit           first_is_d;
    bit           exp_first_d;
    bit           found;
    bit           saw_ok;
    bit           is_d;
    bit           we;
    int           word;
    logic [1:0]   burst;
    logic [3:0]   be;
    logic [31:0]  wd;

    initial begin
        rst = 1'b0;
        ibus_req = 1'b0; ibus_addr = '0; ibus_burst = '0;
        dbus_req = 1'b0; dbus_we = 1'b0; dbus_addr = '0; dbus_be_n = 4'hF;
        dbus_wdata = '0; dbus_burst = '0;
        for (int i = 0; i < 1024; i++) shadow[i] = init_word(i);

        @(negedge clk);
        checkOutput("rst_ce_n", 128'(base_ram_ce_n), 128'd1);
        checkOutput("rst_oe_n", 128'(base_ram_oe_n), 128'd1);
        checkOutput("rst_we_n", 128'(base_ram_we_n), 128'd1);
        checkOutput("rst_be_n", 128'(base_ram_be_n), 128'hF);
        checkOutput("rst_addr", 128'(base_ram_addr), 128'd0);
        checkOutput("rst_oks", 128'({ibus_ok, dbus_ok}), 128'd0);
        checkOutput("rst_ibus_rdata", ibus_rdata, 128'd0);
        checkOutput("rst_dbus_rdata", dbus_rdata, 128'd0);
        @(negedge clk);
        rst = 1'b1;
        $display("[TB] reset released");

        // ibus 4-word burst from word 4
        n0 = addr_log.size();
        applyStimulus(1'b0, 1'b0, 32'h0000_0010, 2'd3, 4'hF, 32'h0, lat, line);
        checkOutput("t1_lat", 128'(lat), 128'd9);
        checkOutput("t1_line", line, 128'h00000044_00000033_00000022_00000011);
        checkOutput("t1_addr_count", 128'(addr_log.size() - n0), 128'd8);
        for (int i = 0; i < 8; i++) begin
            if (n0 + i < addr_log.size())
                checkOutput($sformatf("t1_addr%0d", i), 128'(addr_log[n0 + i]), 128'(4 + i / 2));
        end

        // tie A: dbus wins in both arbitration modes
        applyTieStimulus(32'h0000_0014, 2'd1, 32'h0000_001C, 2'd0, first_is_d, lat1, lat2, d_line, i_line);
        checkOutput("tieA_first_dbus", 128'(first_is_d), 128'd1);
        checkOutput("tieA_lat1", 128'(lat1), 128'd5);
        checkOutput("tieA_lat2", 128'(lat2), 128'd9);
        checkOutput("tieA_dline", d_line, 128'h00000000_00000000_00000033_00000022);
        checkOutput("tieA_iline", i_line, 128'h00000044_00000033_00000022_00000044);

        // byte-enabled write: lanes 0-1 only
        w0 = we_cnt;
        applyStimulus(1'b1, 1'b1, 32'h0000_0100, 2'd0, 4'b1100, 32'hABCD_1234, lat, line);
        checkOutput("t2_lat", 128'(lat), 128'd4);
        checkOutput("t2_we_cycles", 128'(we_cnt - w0), 128'd1);
        checkOutput("t2_we_addr", 128'(we_addr), 128'h40);
        checkOutput("t2_we_be", 128'(we_be), 128'b1100);
        checkOutput("t2_we_data", 128'(we_data), 128'hABCD_1234);
        checkOutput("t2_mem", 128'(mem[64]), 128'h5566_1234);
        shadow[64] = 32'h5566_1234;

        applyStimulus(1'b1, 1'b0, 32'h0000_0100, 2'd0, 4'hF, 32'h0, lat, line);
        checkOutput("t2_rb_lat", 128'(lat), 128'd3);
        checkOutput("t2_rb_line", line, 128'h00000000_00000000_00000033_55661234);

        // tie B: last grant was dbus, so round-robin serves ibus first
`ifdef SRAM_ARB_RR_EN
        exp_first_d = 1'b0;
`else
        exp_first_d = 1'b1;
`endif
        applyTieStimulus(32'h0000_0010, 2'd0, 32'h0000_0018, 2'd0, first_is_d, lat1, lat2, d_line, i_line);
        checkOutput("tieB_first", 128'(first_is_d), 128'(exp_first_d));
        checkOutput("tieB_lat1", 128'(lat1), 128'd3);
        checkOutput("tieB_lat2", 128'(lat2), 128'd7);
        checkOutput("tieB_dline", d_line, 128'h00000000_00000000_00000033_00000011);
        checkOutput("tieB_iline", i_line, 128'h00000044_00000033_00000022_00000033);

        // address wrap at the top of the SRAM
        wrap_exp = '{20'hFFFFF, 20'hFFFFF, 20'h00000, 20'h00000};
        n0 = addr_log.size();
        applyStimulus(1'b0, 1'b0, 32'h003F_FFFC, 2'd1, 4'hF, 32'h0, lat, line);
        checkOutput("wrap_lat", 128'(lat), 128'd5);
        checkOutput("wrap_line", line, 128'h00000044_00000033_CAFE0000_CAFE0001);
        checkOutput("wrap_addr_count", 128'(addr_log.size() - n0), 128'd4);
        for (int i = 0; i < 4; i++) begin
            if (n0 + i < addr_log.size())
                checkOutput($sformatf("wrap_addr%0d", i), 128'(addr_log[n0 + i]), 128'(wrap_exp[i]));
        end

        // reset in the middle of the write pulse
        @(posedge clk);
        #1;
        dbus_we = 1'b1; dbus_addr = 32'h0000_0200; dbus_be_n = 4'h0;
        dbus_wdata = 32'hDEAD_BEEF; dbus_req = 1'b1;
        found = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!base_ram_we_n) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput("rst_reach_pulse", 128'(found), 128'd1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("arst_we_n", 128'(base_ram_we_n), 128'd1);
        checkOutput("arst_ce_n", 128'(base_ram_ce_n), 128'd1);
        checkOutput("arst_bus_released", 128'(dut.drive_bus), 128'd0);
        dbus_req = 1'b0;
        dbus_we  = 1'b0;
        saw_ok   = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw_ok |= dbus_ok;
        end
        rst = 1'b1;
        repeat (6) begin
            @(negedge clk);
            saw_ok |= dbus_ok;
        end
        checkOutput("arst_no_ok", 128'(saw_ok), 128'd0);
        checkOutput("arst_dbus_rdata", dbus_rdata, 128'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 2'd0, 4'hF, 32'h0, lat, line);
        checkOutput("post_rst_lat", 128'(lat), 128'd3);
        checkOutput("post_rst_line", line, 128'h00000000_00000000_00000000_00000011);

        // mixed traffic against the shadow memory
        exp_dbus = 128'h00000000_00000000_00000000_00000011;
        exp_ibus = 128'h0;
        for (int n = 0; n < 24; n++) begin
            is_d  = 1'($urandom_range(0, 1));
            we    = is_d & 1'($urandom_range(0, 1));
            word  = 32'h100 + int'($urandom_range(0, 15));
            burst = 2'($urandom_range(0, 3));
            be    = 4'($urandom_range(0, 15));
            wd    = $urandom;
            applyStimulus(is_d, we, {12'b0, 18'(word), 2'($urandom_range(0, 3))}, burst, be, wd, lat, line);
            if (we) begin
                checkOutput("rnd_wr_lat", 128'(lat), 128'd4);
                for (int b = 0; b < 4; b++) begin
                    if (!be[b]) shadow[word][8*b +: 8] = wd[8*b +: 8];
                end
            end else begin
                exp_line = is_d ? exp_dbus : exp_ibus;
                for (int i = 0; i <= int'(burst); i++) exp_line[32*i +: 32] = shadow[word + i];
                checkOutput("rnd_rd_lat", 128'(lat), 128'(1 + (int'(burst) + 1) * 2));
                checkOutput("rnd_rd_line", line, exp_line);
                if (is_d) exp_dbus = exp_line;
                else      exp_ibus = exp_line;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
